// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one iteration per clock.
// Owns HI/LO; stall freezes ID/EX while an operation is in flight.
//
// Handshake: an op is accepted only when start=1 and the unit is idle
// (stall=0); any start seen while stall=1 is dropped. Completion of
// MULT/DIV is flagged by a single-cycle done pulse, in the cycle in which
// hi/lo first show the new result.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] operand;   // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi;    // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend then quotient bits
  logic             op_div;
  logic             a_sign;
  logic             b_sign;

  // Request decode
  logic             req_md;
  logic             req_div;
  logic             req_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign req_md     = start && (md_control >= 3'd1) && (md_control <= 3'd4);
  assign req_div    = (md_control == 3'd3) || (md_control == 3'd4);
  assign req_signed = (md_control == 3'd1) || (md_control == 3'd3);
  assign abs_a      = (req_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign abs_b      = (req_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Iteration step datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;

  // Combinational step arithmetic shared by the ITER state
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_ok    = ~div_diff[WIDTH];
  end

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Final result formation; divide by zero forces an all-ones quotient,
  // while the remainder naturally equals the dividend.
  always_comb begin
    prod_mag = {acc_hi, acc_lo};
    prod_fix = (a_sign ^ b_sign) ? (~prod_mag + 1'b1) : prod_mag;
    quot_fix = (a_sign ^ b_sign) ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix  = a_sign ? (~acc_hi + 1'b1) : acc_hi;
    if (operand == '0) begin
      quot_fix = '1;
    end
    if (op_div) begin
      res_hi = rem_fix;
      res_lo = quot_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_md) state_next = ITER;
      ITER:    if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: busy whenever an operation is in flight
  always_comb begin
    stall = (state != IDLE);
  end

  // Operand capture and per-cycle iteration registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      operand <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      op_div  <= 1'b0;
      a_sign  <= 1'b0;
      b_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_md) begin
            count   <= '0;
            operand <= req_div ? abs_b : abs_a;
            acc_hi  <= '0;
            acc_lo  <= req_div ? abs_a : abs_b;
            op_div  <= req_div;
            a_sign  <= req_signed & a[WIDTH-1];
            b_sign  <= req_signed & b[WIDTH-1];
          end
        end
        ITER: begin
          count <= count + CW'(1);
          if (op_div) begin
            acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        default: count <= '0;
      endcase
    end
  end

  // HI/LO registers: direct moves when idle, results written from FIX
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state == IDLE && start) begin
      if (md_control == 3'd5) hi <= a;
      if (md_control == 3'd6) lo <= a;
    end
  end

  // Completion pulse, high for the cycle after FIX
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed operations with
// hand-computed results plus a cycle-by-cycle reference model.
module tb_ex_muldiv_unit;

  localparam int W    = 32;
  localparam int BUSY = W + 1;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start;
  logic [2:0]   md;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clock = ~clock;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .md_control (md),
    .a          (a),
    .b          (b),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Arithmetic result of an op as {hi, lo}, from plain integer maths.
  function automatic logic [63:0] md_model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      sx, sy, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'd1: begin q = sx * sy; u = q; end
      3'd2: u = {32'b0, x} * {32'b0, y};
      3'd3: begin
        if (y == 0) u = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          u = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (y == 0) u = {x, 32'hFFFF_FFFF};
        else u = {x % y, x / y};
      end
      default: u = '0;
    endcase
    return u;
  endfunction

  // Model state: busy countdown, pending result, architectural HI/LO.
  int          m_busy;
  logic        m_done;
  logic [W-1:0] m_hi, m_lo;
  logic [63:0] p_res;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy != 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_hi   <= p_res[63:32];
          m_lo   <= p_res[31:0];
          m_done <= 1'b1;
        end
      end else if (start) begin
        case (md)
          3'd1, 3'd2, 3'd3, 3'd4: begin
            p_res  <= md_model(md, a, b);
            m_busy <= BUSY;
          end
          3'd5: m_hi <= a;
          3'd6: m_lo <= a;
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    if (check_en) begin
      check("cyc_stall", W'(stall), W'(m_busy != 0));
      check("cyc_done",  W'(done),  W'(m_done));
      check("cyc_hi",    hi, m_hi);
      check("cyc_lo",    lo, m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    md    = op;
    a     = x;
    b     = y;
    @(negedge clock);
    start = 1'b0;
    md    = 3'd0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Waits (bounded) for done; counts stall cycles seen on the way.
  task automatic wait_done(output int cyc);
    bit ok;
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (done) ok = 1'b1;
      else begin
        if (stall) cyc++;
        @(negedge clock);
      end
    end
    check("done_timeout", W'(ok), W'(1));
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
    int          cyc;
    logic [63:0] mres;
    mres = md_model(op, x, y);
    check({name, "_model_hi"}, mres[63:32], e_hi);
    check({name, "_model_lo"}, mres[31:0], e_lo);
    issue(op, x, y);
    wait_done(cyc);
    check({name, "_stall_cycles"}, W'(cyc), W'(BUSY));
    check({name, "_hi"}, hi, e_hi);
    check({name, "_lo"}, lo, e_lo);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    start = 1'b0;
    md    = 3'd0;
    a     = '0;
    b     = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    reset    = 1'b0;
    check_en = 1'b1;
    check("rst_stall", W'(stall), W'(0));
    check("rst_done",  W'(done),  W'(0));
    check("rst_hi",    hi, 32'h0);
    check("rst_lo",    lo, 32'h0);

    do_op("multu_ff_2",  3'd2, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE);
    check("done_one_cycle", W'(done), W'(1));
    @(negedge clock);
    check("done_drops", W'(done), W'(0));
    do_op("mult_m3_5",   3'd1, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_op("div_m7_2",    3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_7_m2",    3'd3, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD);
    do_op("divu_by0",    3'd4, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF);
    do_op("div_ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000);
    do_op("divu_100_7",  3'd4, 32'd100,       32'd7,          32'h0000_0002, 32'h0000_000E);
    do_op("mult_min_sq", 3'd1, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000);
    do_op("mult_m1_m1",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001);

    // MTHI while idle: visible right after the accepting edge, no stall
    start = 1'b1; md = 3'd5; a = 32'hA5A5_A5A5;
    @(posedge clock); #1;
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_stall", W'(stall), W'(0));
    @(negedge clock);
    start = 1'b0; md = 3'd0;
    @(negedge clock);

    // MTLO during busy is dropped; operands changed after issue have no effect
    issue(3'd2, 32'd6, 32'd7);
    start = 1'b1; md = 3'd6; a = 32'hDEAD_BEEF; b = 32'd99;
    @(negedge clock);
    start = 1'b0; md = 3'd0;
    wait_done(cyc);
    check("busy_mtlo_cycles", W'(cyc), W'(BUSY - 1));
    check("busy_mtlo_hi", hi, 32'h0);
    check("busy_mtlo_lo", lo, 32'd42);

    // Reset in the middle of a divide
    issue(3'd3, 32'd1000, 32'd3);
    repeat (8) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_stall", W'(stall), W'(0));
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_done", W'(done), W'(0));
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check("midrst_no_done", W'(done), W'(0));
    end
    do_op("mult_after_rst", 3'd1, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    // Back-to-back: new DIVU issued in the done cycle of the MULT
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc);
    check("b2b_first_hi", hi, 32'h0000_0001);
    check("b2b_first_lo", lo, 32'h0000_0000);
    issue(3'd4, 32'hFFFF_FFFF, 32'h10);
    wait_done(cyc);
    check("b2b_second_cycles", W'(cyc), W'(BUSY));
    check("b2b_second_hi", hi, 32'h0000_000F);
    check("b2b_second_lo", lo, 32'h0FFF_FFFF);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
